// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC chip bus master.
package rtc_pkg;

  // Bus sequencer states, in the order they are visited.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_A_SET = 3'd1,
    ST_A_STB = 3'd2,
    ST_A_HLD = 3'd3,
    ST_GAP   = 3'd4,
    ST_D_SET = 3'd5,
    ST_D_STB = 3'd6,
    ST_D_HLD = 3'd7
  } state_t;

  // Control pin levels, all active low except AD (0 = address, 1 = data).
  typedef struct packed {
    logic cs;
    logic ad;
    logic wr;
    logic rd;
  } pins_t;

  localparam pins_t PINS_IDLE = 4'b1111;

  // RTC register map.
  localparam logic [7:0] REG_SEC   = 8'h21;
  localparam logic [7:0] REG_MIN   = 8'h22;
  localparam logic [7:0] REG_HOUR  = 8'h23;
  localparam logic [7:0] REG_DAY   = 8'h24;
  localparam logic [7:0] REG_MON   = 8'h25;
  localparam logic [7:0] REG_YEAR  = 8'h26;
  localparam logic [7:0] REG_TSEC  = 8'h31;
  localparam logic [7:0] REG_TMIN  = 8'h32;
  localparam logic [7:0] REG_THOUR = 8'h33;

  // Pin levels presented while in a given state.
  function automatic pins_t pins_for(state_t st, logic is_write);
    pins_t p;
    p = PINS_IDLE;
    case (st)
      ST_A_SET: p = 4'b0011;
      ST_A_STB: p = 4'b0001;
      ST_A_HLD: p = 4'b1011;
      ST_D_SET: p = 4'b0111;
      ST_D_STB: p = is_write ? 4'b0101 : 4'b0110;
      default:  p = PINS_IDLE;
    endcase
    return p;
  endfunction

  // The master drives DatAdd through the whole address phase and through the
  // data phase of a write only; GAP is the turnaround before a read.
  function automatic logic drives_bus(state_t st, logic is_write);
    logic en;
    case (st)
      ST_A_SET, ST_A_STB, ST_A_HLD: en = 1'b1;
      ST_D_SET, ST_D_STB, ST_D_HLD: en = is_write;
      default:                      en = 1'b0;
    endcase
    return en;
  endfunction

  // Selects write data (1) instead of the address (0) onto the bus.
  function automatic logic data_phase(state_t st);
    return (st == ST_D_SET) || (st == ST_D_STB) || (st == ST_D_HLD);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase length counter: flags the last cycle of a T_PH-cycle phase.
module rtc_phase_timer #(
  parameter int T_PH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic last
);

  localparam int            CW       = (T_PH > 1) ? $clog2(T_PH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(T_PH - 1);

  logic [CW-1:0] cnt_reg;

  // Count up inside a phase; the owner clears it whenever a new phase begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign last = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Single-register read/write master for the multiplexed RTC chip bus.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int T_PH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       CS,
  output logic       AD,
  output logic       WR,
  output logic       RD,
  inout  wire  [7:0] DatAdd
);

  state_t     state_reg, state_next;
  logic       accept;
  logic       last;
  logic       we_next;

  logic       we_reg;
  logic [7:0] addr_reg;
  logic [7:0] wdata_reg;
  logic [7:0] rdata_reg;

  pins_t      pins_reg;
  logic       oe_reg;
  logic       dsel_reg;
  logic       busy_reg;
  logic       done_reg;

  // Every state exit happens on the phase's last cycle, so clearing there
  // (and while idle) restarts the count on each state entry.
  rtc_phase_timer #(.T_PH(T_PH)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_reg == ST_IDLE) || last),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept from IDLE, then step one state per phase.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_A_SET;
          accept     = 1'b1;
        end
      end
      ST_A_SET: if (last) state_next = ST_A_STB;
      ST_A_STB: if (last) state_next = ST_A_HLD;
      ST_A_HLD: if (last) state_next = ST_GAP;
      ST_GAP:   if (last) state_next = ST_D_SET;
      ST_D_SET: if (last) state_next = ST_D_STB;
      ST_D_STB: if (last) state_next = ST_D_HLD;
      ST_D_HLD: if (last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Direction used for the upcoming state; a fresh request supplies its own.
  assign we_next = accept ? we : we_reg;

  // Request latches: captured once on acceptance, ignored afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg    <= 1'b0;
      addr_reg  <= 8'h00;
      wdata_reg <= 8'h00;
    end else if (accept) begin
      we_reg    <= we;
      addr_reg  <= addr;
      wdata_reg <= wdata;
    end
  end

  // Pins, bus enable and status flags are registered images of the next
  // state so they change cleanly together with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pins_reg <= PINS_IDLE;
      oe_reg   <= 1'b0;
      dsel_reg <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      pins_reg <= pins_for(state_next, we_next);
      oe_reg   <= drives_bus(state_next, we_next);
      dsel_reg <= data_phase(state_next);
      busy_reg <= (state_next != ST_IDLE);
      done_reg <= (state_reg == ST_D_HLD) && last;
    end
  end

  // Read data is sampled on the closing edge of the read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= 8'h00;
    end else if ((state_reg == ST_D_STB) && last && !we_reg) begin
      rdata_reg <= DatAdd;
    end
  end

  assign DatAdd = oe_reg ? (dsel_reg ? wdata_reg : addr_reg) : 8'hzz;

  assign CS    = pins_reg.cs;
  assign AD    = pins_reg.ad;
  assign WR    = pins_reg.wr;
  assign RD    = pins_reg.rd;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign rdata = rdata_reg;

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus master that turns single-register read/write requests from the control logic into multiplexed address/data cycles on the external RTC chip bus (CS, AD, WR, RD, DatAdd). It sits inside `proyecto2_empaquetado` between the time/date/timer register scheduler and the RTC pins. It handles phase timing, drives the shared tristate bus, and returns captured read data with a completion pulse.

## Interface
- `T_PH`, default 4: cycles per bus phase, minimum 1. At a 100 MHz clock, 4 cycles give 40 ns per phase.
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: transaction request. Sampled only while `busy`=0.
- `we` in 1: 1 = write, 0 = read. Latched with `req`.
- `addr` in 8: RTC register address, e.g. 0x21–0x26 time/date, 0x31–0x33 timer. Latched with `req`.
- `wdata` in 8: write data. Latched with `req`.
- `rdata` out 8: last read value. Holds until the next read completes.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on return to IDLE.
- `CS`, `AD`, `WR`, `RD` out 1 each: active-low chip select, address(0)/data(1) select, write strobe and read strobe.
- `DatAdd` inout 8: multiplexed address/data bus.

## Operation
- **States:** IDLE, A_SET, A_STB, A_HLD, GAP, D_SET, D_STB, D_HLD. Each non-IDLE state lasts exactly `T_PH` cycles, counted by a phase counter that is cleared on every state entry.
- **Pin levels per state** (order CS/AD/WR/RD):
  - IDLE 1/1/1/1
  - A_SET 0/0/1/1
  - A_STB 0/0/0/1
  - A_HLD 1/0/1/1
  - GAP 1/1/1/1
  - D_SET 0/1/1/1
  - D_STB 0/1/0/1 on write, 0/1/1/0 on read
  - D_HLD 1/1/1/1
- **Bus drive:**
  - `DatAdd` carries the latched `addr` in A_SET, A_STB and A_HLD.
  - It carries the latched `wdata` in D_SET, D_STB and D_HLD of a write.
  - It is hi-Z in all other states. GAP is the turnaround cycle, so the DUT never drives during any RD-low cycle.
- **Accept:** in IDLE with `req`=1, latch `we`, `addr` and `wdata`, then go to A_SET. Input changes after acceptance are ignored.
- **Request while busy:** `req` is ignored and not queued. If `req` is held high, a new transaction is accepted in the first IDLE cycle, which is the same cycle `done` is high.
- **Read capture:** on the final edge of D_STB, `rdata` <= `DatAdd`. Writes leave `rdata` unchanged.
- **Completion:** on the final edge of D_HLD, go to IDLE and set `done`=1 for one cycle.
- **Reset** (asynchronous, including mid-transaction):
  - State = IDLE, counter = 0.
  - CS=AD=WR=RD=1, `DatAdd` hi-Z.
  - `busy`=0, `done`=0, `rdata`=0x00.
  - An aborted transaction produces no `done`.

## Timing
- All pin outputs and the tristate enable are registered and derived from the state register only, so they are glitch-free.
- If `req` is accepted at edge 0, `done` is high from edge 7·T_PH to edge 7·T_PH+1. With the default T_PH=4 this is 28 cycles.
- `busy` rises at edge 0 and falls at edge 7·T_PH.
- `rdata` is valid from edge 6·T_PH, before `done`.
- Strobes never overlap: WR and RD are never low together, and neither is low while CS=1.
- The address is stable for a full phase before and after the WR-low strobe. The data phase follows the same rule.
- Back-to-back throughput is one transaction per 7·T_PH+1 cycles. The +1 is the mandatory IDLE cycle.

## Structure
- **Shared package (`rtc_pkg`):**
  - State encoding enum.
  - RTC register address constants: SEC=0x21, MIN=0x22, HOUR=0x23, DAY=0x24, MON=0x25, YEAR=0x26, TSEC=0x31, TMIN=0x32, THOUR=0x33.
  - Idle pin-level constant.
- **Sub-module `rtc_phase_timer`:** counter with clear on state entry and a `last` flag when count = T_PH-1. Width is $clog2(T_PH) with a minimum of 1 bit.
- **Top:** FSM, latches, tristate assignment. Total 150–250 lines.

## Test plan
- **Reset:** assert `reset` for 1 cycle → CS/AD/WR/RD=1, DatAdd=Z, busy=0, done=0, rdata=0x00.
- **Write:** addr 0x21, wdata 0x45, T_PH=4. Bus model decodes 0x21 to slot 1 during WR-low with AD=0, then stores 0x45 on WR-low with AD=1 → slot 1 = 0x45, done at edge 28, DUT never drives during RD low.
- **Read:** addr 0x33, model slot 9 preloaded with 0x09 → RD low for 4 cycles with DatAdd driven only by the model, rdata=0x09 at edge 24, done at edge 28.
- **Held request:** keep `req` high with a second request pulsed mid-transaction → the mid-transaction request is ignored. The next transaction starts in the `done` cycle, and A_SET begins exactly 1 cycle after D_HLD ends.
- **Reset mid-write:** assert `reset` during D_STB → pins return to idle and DatAdd goes hi-Z immediately (no clock needed), no done pulse. A following read of 0x21 completes normally.
- **T_PH=1:** write then read to 0x31 → each transaction takes 7 cycles, done at edge 7, read-back equals the written value.
